// File: rtl/fir_channel_arbiter_pkg.sv
// Shared state encoding and widths for the FIR channel arbiter slice.
// CH_W is fixed by the 2-bit tuser of the shared FIR.
package fir_arb_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam int CH_W   = 2;
    localparam int DW_DEF = 24;
    localparam int WDOG_W = 10;
endpackage

// File: rtl/fir_channel_arbiter_if.sv
// Bundles the per-channel AXI-Stream ports, the FIR request/result streams and status.
// The slave modport is the arbiter's view; master is the surrounding fabric's view.
interface fir_channel_arbiter_if
    import fir_arb_pkg::*;
#(
    parameter int NCH = 4,
    parameter int DW  = DW_DEF
);
    logic [NCH*DW-1:0] ch_s_tdata;
    logic [NCH-1:0]    ch_s_tvalid;
    logic [NCH-1:0]    ch_s_tready;
    logic [NCH-1:0]    ch_mask;

    logic [DW-1:0]     fir_m_tdata;
    logic              fir_m_tvalid;
    logic              fir_m_tready;
    logic [CH_W-1:0]   fir_m_tuser;

    logic [DW-1:0]     fir_s_tdata;
    logic              fir_s_tvalid;
    logic              fir_s_tready;
    logic [CH_W-1:0]   fir_s_tuser;

    logic [NCH*DW-1:0] ch_m_tdata;
    logic [NCH-1:0]    ch_m_tvalid;
    logic [NCH-1:0]    ch_m_tready;

    logic              busy;
    logic              err;

    modport slave (
        input  ch_s_tdata, ch_s_tvalid, ch_mask,
        input  fir_m_tready,
        input  fir_s_tdata, fir_s_tvalid, fir_s_tuser,
        input  ch_m_tready,
        output ch_s_tready,
        output fir_m_tdata, fir_m_tvalid, fir_m_tuser,
        output fir_s_tready,
        output ch_m_tdata, ch_m_tvalid,
        output busy, err
    );

    modport master (
        output ch_s_tdata, ch_s_tvalid, ch_mask,
        output fir_m_tready,
        output fir_s_tdata, fir_s_tvalid, fir_s_tuser,
        output ch_m_tready,
        input  ch_s_tready,
        input  fir_m_tdata, fir_m_tvalid, fir_m_tuser,
        input  fir_s_tready,
        input  ch_m_tdata, ch_m_tvalid,
        input  busy, err
    );
endinterface

// File: rtl/fir_channel_arbiter_rr.sv
// Combinational round-robin picker: first requester found circularly after ptr_i.
// Zero latency; no handshaking of its own.
module rr_arbiter
    import fir_arb_pkg::*;
#(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0]  req_i,
    input  logic [CH_W-1:0] ptr_i,
    output logic [CH_W-1:0] grant_o,
    output logic            any_req_o
);

    function automatic int wrap_add(input logic [CH_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        return (s >= NCH) ? (s - NCH) : s;
    endfunction

    // Scan farthest-first so the nearest requester after ptr_i overwrites the rest.
    always_comb begin
        grant_o   = '0;
        any_req_o = 1'b0;
        for (int k = NCH; k >= 1; k--) begin
            for (int i = 0; i < NCH; i++) begin
                if (req_i[i] && (wrap_add(ptr_i, k) == i)) begin
                    grant_o   = CH_W'(i);
                    any_req_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fir_channel_arbiter.sv
// Shares one time-multiplexed FIR among NCH streams: one sample in flight, result routed by tuser.
// Optional FIR_ARB_WDOG_EN adds a WAIT-state watchdog; holds results until the channel sink is ready.
module fir_channel_arbiter
    import fir_arb_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int DW          = DW_DEF,
    parameter int WDOG_CYCLES = 512
) (
    input  logic                  s_axis_aclk,
    input  logic                  s_axis_arstn,
    fir_channel_arbiter_if.slave  bus
);

    localparam logic [CH_W-1:0] PTR_RST = CH_W'(NCH - 1);

    state_t          state_q, state_d;
    logic [CH_W-1:0] grant_q, grant_d;
    logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [DW-1:0]   res_q, res_d;
    logic            err_q, err_d;

    logic [NCH-1:0]  req;
    logic [NCH-1:0]  grant_oh;
    logic            grant_rdy;
    logic [CH_W-1:0] pick;
    logic            any_req;

`ifdef FIR_ARB_WDOG_EN
    localparam logic [WDOG_W-1:0] WDOG_LIM = WDOG_W'(WDOG_CYCLES - 1);
    logic [WDOG_W-1:0] wdog_q, wdog_d;
`endif

    assign req = bus.ch_s_tvalid & bus.ch_mask;

    rr_arbiter #(.NCH(NCH)) u_rr (
        .req_i     (req),
        .ptr_i     (rr_ptr_q),
        .grant_o   (pick),
        .any_req_o (any_req)
    );

    always_comb begin
        grant_oh = '0;
        for (int i = 0; i < NCH; i++) begin
            grant_oh[i] = (grant_q == CH_W'(i));
        end
    end

    assign grant_rdy = |(grant_oh & bus.ch_m_tready);

    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_arstn) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= PTR_RST;
            res_q    <= '0;
            err_q    <= 1'b0;
`ifdef FIR_ARB_WDOG_EN
            wdog_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            res_q    <= res_d;
            err_q    <= err_d;
`ifdef FIR_ARB_WDOG_EN
            wdog_q   <= wdog_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        res_d    = res_q;
        err_d    = err_q;
`ifdef FIR_ARB_WDOG_EN
        wdog_d   = wdog_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.fir_s_tvalid) err_d = 1'b1;
                if (any_req) begin
                    grant_d = pick;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // A result before the sample has even been accepted cannot belong to us.
                if (bus.fir_s_tvalid) err_d = 1'b1;
                if (bus.fir_m_tready) begin
                    state_d = WAIT;
`ifdef FIR_ARB_WDOG_EN
                    wdog_d  = '0;
`endif
                end
            end
            WAIT: begin
                if (bus.fir_s_tvalid) begin
                    if (bus.fir_s_tuser == grant_q) begin
                        res_d   = bus.fir_s_tdata;
                        state_d = OUT;
                    end else begin
                        err_d    = 1'b1;
                        rr_ptr_d = grant_q;
                        state_d  = IDLE;
                    end
                end
`ifdef FIR_ARB_WDOG_EN
                else if (wdog_q == WDOG_LIM) begin
                    err_d    = 1'b1;
                    rr_ptr_d = grant_q;
                    state_d  = IDLE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
`endif
            end
            OUT: begin
                if (grant_rdy) begin
                    rr_ptr_d = grant_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.fir_m_tvalid = 1'b0;
        bus.fir_m_tdata  = '0;
        bus.fir_m_tuser  = '0;
        bus.ch_s_tready  = '0;
        bus.fir_s_tready = 1'b0;
        bus.ch_m_tvalid  = '0;
        bus.ch_m_tdata   = '0;
        case (state_q)
            ISSUE: begin
                bus.fir_m_tvalid = 1'b1;
                bus.fir_m_tuser  = grant_q;
                // The FIR gates its input ready with its output ready, so keep the result path open.
                bus.fir_s_tready = 1'b1;
                bus.ch_s_tready  = grant_oh & {NCH{bus.fir_m_tready}};
                for (int i = 0; i < NCH; i++) begin
                    if (grant_oh[i]) bus.fir_m_tdata = bus.ch_s_tdata[i*DW +: DW];
                end
            end
            WAIT: begin
                bus.fir_s_tready = 1'b1;
            end
            OUT: begin
                bus.ch_m_tvalid = grant_oh;
                for (int i = 0; i < NCH; i++) begin
                    if (grant_oh[i]) bus.ch_m_tdata[i*DW +: DW] = res_q;
                end
            end
            default: ;
        endcase
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.err  = err_q;

endmodule

// File: tb/tb_fir_channel_arbiter.sv
// Directed bench for fir_channel_arbiter with a 129-cycle FIR stub that returns data ^ 0xA5A5A5.
module tb_fir_channel_arbiter;
    import fir_arb_pkg::*;

    localparam int NCH = 4;
    localparam int DW  = 24;
    localparam int LAT = 129;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    fir_channel_arbiter_if #(.NCH(NCH), .DW(DW)) bus ();

    fir_channel_arbiter #(.NCH(NCH), .DW(DW), .WDOG_CYCLES(512)) dut (
        .s_axis_aclk  (clk),
        .s_axis_arstn (rstn),
        .bus          (bus)
    );

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    int              src_cnt [NCH];
    logic [NCH-1:0]  src_hs;
    logic [1:0]      grant_log[$];
    logic [1:0]      out_ch[$];
    logic [DW-1:0]   out_dat[$];
    int              issue_cyc;
    logic            stray_rdy;
    logic            ch1_vld_seen;

    int              lat_cnt;
    logic [DW-1:0]   cap_dat;
    logic [1:0]      cap_user;
    logic            res_fire;
    logic            stub_never = 1'b0;
    logic            bad_ch1    = 1'b0;
    logic            spur_req   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Sources, FIR stub and monitors all act on the falling edge; transfers are judged for the next rising edge.
    always @(negedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NCH; i++) src_cnt[i] = 0;
            src_hs = '0;
            lat_cnt = 0;
            res_fire = 1'b0;
            bus.fir_s_tvalid = 1'b0;
            bus.fir_s_tdata = '0;
            bus.fir_s_tuser = '0;
            grant_log.delete();
            out_ch.delete();
            out_dat.delete();
            issue_cyc = 0;
            stray_rdy = 1'b0;
            ch1_vld_seen = 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) if (src_hs[i]) src_cnt[i] = src_cnt[i] + 1;
            src_hs = '0;
            if (res_fire) begin
                bus.fir_s_tvalid = 1'b0;
                res_fire = 1'b0;
            end
            if (lat_cnt > 0) begin
                lat_cnt = lat_cnt - 1;
                if (lat_cnt == 0 && !stub_never) begin
                    bus.fir_s_tvalid = 1'b1;
                    bus.fir_s_tdata  = cap_dat ^ 24'hA5A5A5;
                    bus.fir_s_tuser  = (bad_ch1 && cap_user == 2'd1) ? 2'd3 : cap_user;
                end
            end
            if (spur_req) begin
                bus.fir_s_tvalid = 1'b1;
                bus.fir_s_tdata  = 24'h123456;
                bus.fir_s_tuser  = 2'd0;
                res_fire = 1'b1;
            end
            if (bus.fir_m_tvalid && bus.fir_m_tready) begin
                lat_cnt   = LAT;
                cap_dat   = bus.fir_m_tdata;
                cap_user  = bus.fir_m_tuser;
                grant_log.push_back(bus.fir_m_tuser);
                issue_cyc = cyc + 1;
            end
            if (bus.fir_s_tvalid && bus.fir_s_tready) res_fire = 1'b1;
            for (int i = 0; i < NCH; i++) begin
                if (bus.ch_s_tvalid[i] && bus.ch_s_tready[i]) src_hs[i] = 1'b1;
                if (bus.ch_m_tvalid[i] && bus.ch_m_tready[i]) begin
                    out_ch.push_back(2'(i));
                    out_dat.push_back(bus.ch_m_tdata[i*DW +: DW]);
                end
            end
            if ((bus.ch_s_tready & ~bus.ch_mask) != '0) stray_rdy = 1'b1;
            if (bus.ch_m_tvalid[1]) ch1_vld_seen = 1'b1;
        end
        for (int i = 0; i < NCH; i++) bus.ch_s_tdata[i*DW +: DW] = DW'((i + 1) << 20) + DW'(src_cnt[i]);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        bus.ch_s_tvalid  = '0;
        bus.ch_mask      = '0;
        bus.ch_m_tready  = '0;
        bus.fir_m_tready = 1'b1;
        stub_never = 1'b0;
        bad_ch1    = 1'b0;
        spur_req   = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.ch_s_tvalid  = 4'hF;
        bus.ch_mask      = 4'hF;
        bus.ch_m_tready  = 4'hF;
        bus.fir_m_tready = 1'b1;
        repeat (3) tick();
        total++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got=%0b want=0", bus.busy); else passed++;
        total++; if (bus.err !== 1'b0) $display("FAIL rst_err got=%0b want=0", bus.err); else passed++;
        total++; if (bus.fir_m_tvalid !== 1'b0) $display("FAIL rst_fir_m_tvalid got=%0b want=0", bus.fir_m_tvalid); else passed++;
        total++; if (bus.fir_m_tdata !== 24'h0) $display("FAIL rst_fir_m_tdata got=%0h want=0", bus.fir_m_tdata); else passed++;
        total++; if (bus.ch_s_tready !== 4'h0) $display("FAIL rst_ch_s_tready got=%0h want=0", bus.ch_s_tready); else passed++;
        total++; if (bus.fir_s_tready !== 1'b0) $display("FAIL rst_fir_s_tready got=%0b want=0", bus.fir_s_tready); else passed++;
        total++; if (bus.ch_m_tvalid !== 4'h0) $display("FAIL rst_ch_m_tvalid got=%0h want=0", bus.ch_m_tvalid); else passed++;
        total++; if (bus.ch_m_tdata !== 96'h0) $display("FAIL rst_ch_m_tdata got=%0h want=0", bus.ch_m_tdata); else passed++;
        rstn = 1'b1;
        tick();
        total++; if (bus.fir_m_tvalid !== 1'b1 || bus.fir_m_tuser !== 2'd0)
            $display("FAIL first_grant got vld=%0b user=%0d want vld=1 user=0", bus.fir_m_tvalid, bus.fir_m_tuser); else passed++;
        total++; if (bus.fir_m_tdata !== 24'h100000) $display("FAIL first_issue_data got=%0h want=100000", bus.fir_m_tdata); else passed++;
    endtask

    task automatic test_round_robin();
        logic [1:0]    exp_ch [5];
        logic [DW-1:0] exp_dat[5];
        int t;
        exp_ch  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_dat = '{24'hB5A5A5, 24'h85A5A5, 24'h95A5A5, 24'hE5A5A5, 24'hB5A5A4};
        apply_reset();
        bus.ch_mask = 4'hF; bus.ch_m_tready = 4'hF; bus.ch_s_tvalid = 4'hF;
        t = 0;
        while (out_ch.size() < 5 && t < 1200) begin tick(); t++; end
        total++; if (out_ch.size() < 5) $display("FAIL rr_timeout got=%0d outputs want=5", out_ch.size()); else passed++;
        for (int k = 0; k < 5; k++) begin
            total++; if (k >= grant_log.size() || grant_log[k] !== exp_ch[k])
                $display("FAIL rr_grant[%0d] got=%0d want=%0d", k, (k < grant_log.size()) ? grant_log[k] : 2'bxx, exp_ch[k]); else passed++;
            total++; if (k >= out_ch.size() || out_ch[k] !== exp_ch[k] || out_dat[k] !== exp_dat[k])
                $display("FAIL rr_out[%0d] got ch=%0d dat=%0h want ch=%0d dat=%0h", k,
                         (k < out_ch.size()) ? out_ch[k] : 2'bxx, (k < out_dat.size()) ? out_dat[k] : 24'hx, exp_ch[k], exp_dat[k]); else passed++;
        end
    endtask

    task automatic test_mask();
        logic [1:0]    exp_ch [4];
        logic [DW-1:0] exp_dat[4];
        int t;
        exp_ch  = '{2'd0, 2'd2, 2'd0, 2'd2};
        exp_dat = '{24'hB5A5A5, 24'h95A5A5, 24'hB5A5A4, 24'h95A5A4};
        apply_reset();
        bus.ch_mask = 4'b0101; bus.ch_m_tready = 4'hF; bus.ch_s_tvalid = 4'hF;
        t = 0;
        while (out_ch.size() < 4 && t < 1000) begin tick(); t++; end
        for (int k = 0; k < 4; k++) begin
            total++; if (k >= out_ch.size() || out_ch[k] !== exp_ch[k] || out_dat[k] !== exp_dat[k])
                $display("FAIL mask_out[%0d] got ch=%0d dat=%0h want ch=%0d dat=%0h", k,
                         (k < out_ch.size()) ? out_ch[k] : 2'bxx, (k < out_dat.size()) ? out_dat[k] : 24'hx, exp_ch[k], exp_dat[k]); else passed++;
        end
        total++; if (stray_rdy !== 1'b0) $display("FAIL mask_ready got=%0b stray ready want=0", stray_rdy); else passed++;
    endtask

    task automatic test_backpressure();
        logic [NCH*DW-1:0] held;
        logic bad;
        int t;
        apply_reset();
        bus.ch_mask = 4'hF; bus.ch_m_tready = 4'b1101; bus.ch_s_tvalid = 4'b0010;
        t = 0;
        while (bus.ch_m_tvalid[1] !== 1'b1 && t < 400) begin tick(); t++; end
        total++; if (bus.ch_m_tvalid !== 4'b0010) $display("FAIL bp_valid got=%0h want=2", bus.ch_m_tvalid); else passed++;
        total++; if (bus.ch_m_tdata !== {24'h0, 24'h0, 24'h85A5A5, 24'h0})
            $display("FAIL bp_data got=%0h want=%0h", bus.ch_m_tdata, {24'h0, 24'h0, 24'h85A5A5, 24'h0}); else passed++;
        held = bus.ch_m_tdata;
        bad = 1'b0;
        repeat (50) begin
            tick();
            if (bus.ch_m_tvalid !== 4'b0010 || bus.ch_m_tdata !== held) bad = 1'b1;
        end
        total++; if (bad !== 1'b0) $display("FAIL bp_hold got=unstable want=stable"); else passed++;
        total++; if (grant_log.size() !== 1) $display("FAIL bp_no_issue got=%0d issues want=1", grant_log.size()); else passed++;
        bus.ch_m_tready = 4'hF;
        tick();
        total++; if (bus.ch_m_tvalid !== 4'h0 || out_ch.size() !== 1)
            $display("FAIL bp_release got vld=%0h outs=%0d want vld=0 outs=1", bus.ch_m_tvalid, out_ch.size()); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL bp_idle got busy=%0b want=0", bus.busy); else passed++;
    endtask

    task automatic test_tuser_mismatch();
        int t;
        apply_reset();
        bad_ch1 = 1'b1;
        bus.ch_mask = 4'hF; bus.ch_m_tready = 4'hF; bus.ch_s_tvalid = 4'hF;
        t = 0;
        while (bus.err !== 1'b1 && t < 800) begin tick(); t++; end
        total++; if (bus.err !== 1'b1) $display("FAIL mm_err got=%0b want=1", bus.err); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL mm_idle got busy=%0b want=0", bus.busy); else passed++;
        total++; if (out_ch.size() !== 1 || ch1_vld_seen !== 1'b0)
            $display("FAIL mm_drop got outs=%0d ch1_vld=%0b want outs=1 ch1_vld=0", out_ch.size(), ch1_vld_seen); else passed++;
        t = 0;
        while (grant_log.size() < 3 && t < 50) begin tick(); t++; end
        total++; if (grant_log.size() < 3 || grant_log[2] !== 2'd2)
            $display("FAIL mm_next_grant got=%0d want=2", (grant_log.size() >= 3) ? grant_log[2] : 2'bxx); else passed++;
        total++; if (bus.err !== 1'b1) $display("FAIL mm_sticky got=%0b want=1", bus.err); else passed++;
    endtask

    task automatic test_watchdog();
        int t;
        apply_reset();
        stub_never = 1'b1;
        bus.ch_mask = 4'hF; bus.ch_m_tready = 4'hF; bus.ch_s_tvalid = 4'b0001;
        t = 0;
        while (grant_log.size() < 1 && t < 20) begin tick(); t++; end
        total++; if (grant_log.size() !== 1) $display("FAIL wd_issue got=%0d issues want=1", grant_log.size()); else passed++;
        bus.ch_s_tvalid = '0;
`ifdef FIR_ARB_WDOG_EN
        t = 0;
        while (bus.err !== 1'b1 && t < 700) begin tick(); t++; end
        total++; if (bus.err !== 1'b1 || (cyc - issue_cyc) !== 512)
            $display("FAIL wd_timeout got err=%0b after=%0d want err=1 after=512", bus.err, cyc - issue_cyc); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL wd_idle got busy=%0b want=0", bus.busy); else passed++;
`else
        repeat (600) tick();
        total++; if (bus.busy !== 1'b1) $display("FAIL wd_wait got busy=%0b want=1", bus.busy); else passed++;
        total++; if (bus.err !== 1'b0) $display("FAIL wd_noerr got err=%0b want=0", bus.err); else passed++;
`endif
    endtask

    task automatic test_reset_in_wait();
        int t;
        apply_reset();
        bus.ch_mask = 4'hF; bus.ch_m_tready = 4'hF;
        spur_req = 1'b1;
        tick();
        spur_req = 1'b0;
        tick();
        total++; if (bus.err !== 1'b1) $display("FAIL spur_err got=%0b want=1", bus.err); else passed++;
        bus.ch_s_tvalid = 4'hF;
        t = 0;
        while (grant_log.size() < 1 && t < 20) begin tick(); t++; end
        repeat (10) tick();
        total++; if (bus.busy !== 1'b1 || bus.fir_s_tready !== 1'b1)
            $display("FAIL riw_in_wait got busy=%0b rdy=%0b want 1 1", bus.busy, bus.fir_s_tready); else passed++;
        rstn = 1'b0;
        tick();
        total++; if (bus.busy !== 1'b0 || bus.err !== 1'b0)
            $display("FAIL riw_status got busy=%0b err=%0b want 0 0", bus.busy, bus.err); else passed++;
        total++; if (bus.fir_m_tvalid !== 1'b0 || bus.fir_s_tready !== 1'b0 || bus.ch_m_tvalid !== 4'h0 || bus.ch_s_tready !== 4'h0)
            $display("FAIL riw_outputs got fmv=%0b fsr=%0b cmv=%0h csr=%0h want all 0",
                     bus.fir_m_tvalid, bus.fir_s_tready, bus.ch_m_tvalid, bus.ch_s_tready); else passed++;
        rstn = 1'b1;
        tick();
        total++; if (bus.fir_m_tvalid !== 1'b1 || bus.fir_m_tuser !== 2'd0)
            $display("FAIL riw_first_grant got vld=%0b user=%0d want vld=1 user=0", bus.fir_m_tvalid, bus.fir_m_tuser); else passed++;
    endtask

    initial begin
        bus.ch_s_tvalid  = '0;
        bus.ch_mask      = '0;
        bus.ch_m_tready  = '0;
        bus.fir_m_tready = 1'b1;
        test_reset();
        test_round_robin();
        test_mask();
        test_backpressure();
        test_tuser_mismatch();
        test_watchdog();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout got=%0d checks done want=run complete", total);
        $fatal(1);
    end

endmodule
